// File: rtl/memory_responder_pkg.sv
// memory_responder_pkg: shared widths, defaults, pipeline stage type and in-flight counter update
package memory_responder_pkg;
  localparam int MEM_WORD_W = 16;
  localparam int MEM_LATENCY_DEFAULT = 4;
  localparam int MEM_ADDR_W_DEFAULT = 16;
  localparam int CNT_W = 4;
  typedef struct packed {
    logic                  valid;
    logic [MEM_WORD_W-1:0] data;
  } stage_t;
  function automatic logic [CNT_W-1:0] next_count(input logic [CNT_W-1:0] c, input logic inc,
                                                  input logic dec, input logic [CNT_W-1:0] max);
    return (inc && !dec) ? ((c == max) ? c : c + 1'b1) :
           (dec && !inc && c != '0) ? c - 1'b1 : c;
  endfunction
endpackage

// File: rtl/mem_pipe_stage.sv
// mem_pipe_stage: one valid+data register stage of the read-return pipeline
module mem_pipe_stage
  import memory_responder_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  stage_t d,
  output stage_t q
);
  always_ff @(posedge clk or posedge rst)
    if (rst) q <= '0;
    else q <= d;
endmodule

// File: rtl/memory_responder.sv
// memory_responder: main-memory model with posted writes and pipelined fixed-latency reads
module memory_responder
  import memory_responder_pkg::*;
#(
  parameter int ADDR_W  = MEM_ADDR_W_DEFAULT,
  parameter int LATENCY = MEM_LATENCY_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [ADDR_W-1:0]     mem_addr,
  input  logic [MEM_WORD_W-1:0] mem_write_data,
  output logic                  mem_data_valid,
  output logic [MEM_WORD_W-1:0] mem_read_data,
  output logic                  mem_busy
);
  logic [MEM_WORD_W-1:0] mem [0:(1<<(ADDR_W-1))-1];
  logic [ADDR_W-2:0] idx;
  logic unused_lsb;
  logic [CNT_W-1:0] count;
  stage_t [LATENCY:0] tap;
  assign idx = mem_addr[ADDR_W-1:1];
  assign unused_lsb = mem_addr[0];
  // write-first: a same-cycle write is forwarded into the captured read value
  assign tap[0] = '{valid: mem_read, data: mem_read ? (mem_write ? mem_write_data : mem[idx]) : '0};
  always_ff @(posedge clk)
    if (mem_write) mem[idx] <= mem_write_data;
  for (genvar i = 0; i < LATENCY; i++) begin : g_stage
    mem_pipe_stage u_stage (.clk(clk), .rst(rst), .d(tap[i]), .q(tap[i+1]));
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) count <= '0;
    else count <= next_count(count, mem_read, tap[LATENCY].valid, CNT_W'(LATENCY));
  assign mem_data_valid = tap[LATENCY].valid;
  assign mem_read_data = tap[LATENCY].valid ? tap[LATENCY].data : '0;
  assign mem_busy = count != '0;
endmodule
